// File: rtl/ebi_cmd_deser.sv
// EBI write-path deserialiser: packs 16-bit MCU writes into DATA_WIDTH beats and emits
// each header-framed packet as an AXI-stream master.
module ebi_cmd_deser #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_ena,
  input  logic [15:0]           wr_data,
  output logic                  wr_ready,
  input  logic                  err_clr,
  output logic                  err_ovf,
  output logic                  err_hdr,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  localparam int unsigned WPB = DATA_WIDTH / 16;
  localparam int unsigned WCW = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned LW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [LW-1:0]         beats_left_q, beats_left_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_hdr_q, err_hdr_d;
  logic                  wr_ena_q;
  logic                  stb;

  // wr_ena_q resets high so a strobe held across reset release is not a write
  assign stb = wr_ena & ~wr_ena_q;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    beats_left_d = beats_left_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    err_ovf_d    = err_clr ? 1'b0 : err_ovf_q;
    err_hdr_d    = err_clr ? 1'b0 : err_hdr_q;

    if (stb && !wr_ready_q) begin
      err_ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (stb) begin
          if (wr_data[15]) begin
            beats_left_d = wr_data[LW-1:0];
            state_d      = LOAD;
          end else begin
            err_hdr_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (stb) begin
          for (int unsigned i = 0; i < WPB; i++) begin
            if (word_cnt_q == WCW'(i)) begin
              tdata_d[16*i +: 16] = wr_data;
            end
          end
          if (word_cnt_q == WCW'(WPB - 1)) begin
            word_cnt_d = '0;
            tvalid_d   = 1'b1;
            tlast_d    = (beats_left_q == '0);
            state_d    = SEND;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            tlast_d = 1'b0;
            state_d = IDLE;
          end else begin
            beats_left_d = beats_left_q - 1'b1;
            state_d      = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d = (state_d != SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      beats_left_q <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      wr_ready_q   <= 1'b1;
      err_ovf_q    <= 1'b0;
      err_hdr_q    <= 1'b0;
      wr_ena_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      beats_left_q <= beats_left_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      wr_ready_q   <= wr_ready_d;
      err_ovf_q    <= err_ovf_d;
      err_hdr_q    <= err_hdr_d;
      wr_ena_q     <= wr_ena;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign err_ovf       = err_ovf_q;
  assign err_hdr       = err_hdr_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_ebi_cmd_deser.sv
// Scoreboard bench for ebi_cmd_deser: stimulus queues expected beats, a negedge monitor
// checks every valid beat against the queue head.
module tb_ebi_cmd_deser;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_ena = 1'b1;
  logic [15:0]  wr_data = 16'h0000;
  logic         wr_ready;
  logic         err_clr = 1'b0;
  logic         err_ovf;
  logic         err_hdr;
  logic         tvalid;
  logic         tready = 1'b0;
  logic [127:0] tdata;
  logic         tlast;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int rdy_mode = 0;  // 0: tready low, 1: tready high, 2: random

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;
  beat_t exp_q[$];

  ebi_cmd_deser #(
    .DATA_WIDTH(128),
    .MAX_BEATS (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_ena       (wr_ena),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .err_clr      (err_clr),
    .err_ovf      (err_ovf),
    .err_hdr      (err_hdr),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata),
    .m_axis_tlast (tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every cycle with tvalid must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && tvalid) begin
      valid_cyc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h last %b, expected no beat", tdata, tlast);
      end else begin
        check("beat_data", tdata, exp_q[0].data);
        check("beat_last", 128'(tlast), 128'(exp_q[0].last));
        if (tready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [127:0] beat_of(input logic [15:0] base);
    logic [127:0] d;
    for (int n = 0; n < 8; n++) d[16*n +: 16] = base + 16'(n);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write strobe; optionally waits for wr_ready and pushes an expected beat.
  task automatic send_word(input logic [15:0] w, input bit wait_rdy, input bit push,
                           input beat_t b);
    if (wait_rdy) begin
      int k = 0;
      while (!wr_ready && k < 300) begin
        tick();
        k++;
      end
      if (!wr_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_ready_timeout: got 0, expected 1 within 300 cycles");
      end
    end
    wr_data = w;
    wr_ena  = 1'b1;
    tick();
    if (push) exp_q.push_back(b);
    wr_ena = 1'b0;
    tick();
  endtask

  task automatic send_beat(input logic [15:0] base, input bit last);
    beat_t b;
    b.data = beat_of(base);
    b.last = last;
    for (int n = 0; n < 8; n++) send_word(base + 16'(n), 1'b1, n == 7, b);
  endtask

  task automatic send_hdr(input logic [15:0] h);
    beat_t b;
    b = '0;
    send_word(h, 1'b1, 1'b0, b);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || tvalid) && k < 300) begin
      tick();
      k++;
    end
    check("queue_drained", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    beat_t nb;
    int    v0;
    nb = '0;
    // Reset with wr_ena held high across release
    repeat (3) tick();
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_tlast", 128'(tlast), 128'(0));
    check("rst_tdata", tdata, 128'(0));
    check("rst_wr_ready", 128'(wr_ready), 128'(1));
    check("rst_errs", 128'({err_ovf, err_hdr}), 128'(0));
    rst_n = 1'b1;
    repeat (3) tick();
    wr_ena = 1'b0;
    repeat (2) tick();
    check("held_ena_no_capture", 128'(err_hdr), 128'(0));
    check("held_ena_ready", 128'(wr_ready), 128'(1));

    // 1-beat packet, tready always high
    rdy_mode = 1;
    tick();
    v0 = valid_cyc;
    send_hdr(16'h8000);
    send_beat(16'h0001, 1'b1);
    drain();
    check("one_beat_valid_cycles", 128'(valid_cyc - v0), 128'(1));
    check("one_beat_idle_ready", 128'(wr_ready), 128'(1));

    // 3-beat packet with a 5-cycle stall on beat 2
    send_hdr(16'h8002);
    send_beat(16'h0100, 1'b0);
    for (int n = 0; n < 7; n++) send_word(16'h0200 + 16'(n), 1'b1, 1'b0, nb);
    rdy_mode = 0;
    nb.data = beat_of(16'h0200);
    nb.last = 1'b0;
    send_word(16'h0207, 1'b1, 1'b1, nb);
    repeat (4) tick();
    check("stall_wr_ready", 128'(wr_ready), 128'(0));
    rdy_mode = 1;
    send_beat(16'h0300, 1'b1);
    drain();

    // Write during SEND is dropped and flagged
    send_hdr(16'h8001);
    for (int n = 0; n < 7; n++) send_word(16'h0400 + 16'(n), 1'b1, 1'b0, nb);
    rdy_mode = 0;
    nb.data = beat_of(16'h0400);
    nb.last = 1'b0;
    send_word(16'h0407, 1'b1, 1'b1, nb);
    send_word(16'hdead, 1'b0, 1'b0, nb);
    check("ovf_set", 128'(err_ovf), 128'(1));
    check("ovf_wr_ready", 128'(wr_ready), 128'(0));
    rdy_mode = 1;
    send_beat(16'h0500, 1'b1);
    drain();
    check("ovf_sticky", 128'(err_ovf), 128'(1));
    pulse_clr();
    check("ovf_cleared", 128'(err_ovf), 128'(0));

    // Bad header then a good packet
    send_hdr(16'h0003);
    check("hdr_err_set", 128'(err_hdr), 128'(1));
    check("hdr_err_idle", 128'(wr_ready), 128'(1));
    send_hdr(16'h8000);
    send_beat(16'h0600, 1'b1);
    drain();
    pulse_clr();
    check("hdr_err_cleared", 128'(err_hdr), 128'(0));

    // Reset mid-beat drops the partial packet
    send_hdr(16'h8000);
    for (int n = 0; n < 4; n++) send_word(16'h0700 + 16'(n), 1'b1, 1'b0, nb);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_tvalid", 128'(tvalid), 128'(0));
    check("midrst_tdata", tdata, 128'(0));
    check("midrst_wr_ready", 128'(wr_ready), 128'(1));
    rst_n = 1'b1;
    tick();
    send_hdr(16'h8000);
    send_beat(16'h0800, 1'b1);
    drain();

    // Max-length packet with random backpressure
    rdy_mode = 2;
    send_hdr(16'h800f);
    for (int b = 0; b < 16; b++) send_beat(16'h1000 + 16'(b * 8), b == 15);
    drain();
    rdy_mode = 1;
    tick();
    check("final_tvalid", 128'(tvalid), 128'(0));
    check("final_idle_ready", 128'(wr_ready), 128'(1));
    check("final_errs", 128'({err_ovf, err_hdr}), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
